// File: rtl/nested_index_counter.sv
// Two-level index generator: walks an inner index inside an outer index,
// advancing only on accepted beats (valid_o && en_i), and reports frame status.
module nested_index_counter #(
  parameter int INNER_WIDTH = 16,
  parameter int OUTER_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   clear_i,
  input  logic                   en_i,
  input  logic [INNER_WIDTH-1:0] inner_max_i,
  input  logic [OUTER_WIDTH-1:0] outer_max_i,
  output logic [INNER_WIDTH-1:0] inner_o,
  output logic [OUTER_WIDTH-1:0] outer_o,
  output logic                   valid_o,
  output logic                   first_o,
  output logic                   last_o,
  output logic                   inner_wrap_o,
  output logic                   done_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [INNER_WIDTH-1:0] INNER_ONE = 1;
  localparam logic [OUTER_WIDTH-1:0] OUTER_ONE = 1;

  state_t                 state_q;
  logic [INNER_WIDTH-1:0] inner_q;
  logic [OUTER_WIDTH-1:0] outer_q;
  logic [INNER_WIDTH-1:0] inner_max_q;
  logic [OUTER_WIDTH-1:0] outer_max_q;
  logic                   done_q;
  logic                   run;
  logic                   at_inner_max;
  logic                   at_outer_max;

  // Status flags look only at registered state and the latched limits,
  // so they never depend on en_i.
  assign run          = (state_q == RUN);
  assign at_inner_max = (inner_q == inner_max_q);
  assign at_outer_max = (outer_q == outer_max_q);

  assign inner_o      = inner_q;
  assign outer_o      = outer_q;
  assign valid_o      = run;
  assign done_o       = done_q;
  assign first_o      = run && (inner_q == '0) && (outer_q == '0);
  assign inner_wrap_o = run && at_inner_max;
  assign last_o       = run && at_inner_max && at_outer_max;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      inner_q     <= '0;
      outer_q     <= '0;
      inner_max_q <= '0;
      outer_max_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear_i) begin
        // Aborted frames return to idle without a done pulse.
        state_q <= IDLE;
        inner_q <= '0;
        outer_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            inner_q <= '0;
            outer_q <= '0;
            if (start_i) begin
              inner_max_q <= inner_max_i;
              outer_max_q <= outer_max_i;
              state_q     <= RUN;
            end
          end
          RUN: begin
            if (en_i) begin
              if (at_inner_max && at_outer_max) begin
                state_q <= IDLE;
                inner_q <= '0;
                outer_q <= '0;
                done_q  <= 1'b1;
              end else if (at_inner_max) begin
                inner_q <= '0;
                outer_q <= outer_q + OUTER_ONE;
              end else begin
                inner_q <= inner_q + INNER_ONE;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            inner_q <= '0;
            outer_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nested_index_counter.sv
// Directed bench for nested_index_counter: a 16-bit instance for the main
// scenarios and a 2/3-bit instance for the all-ones limit frame.
module tb_nested_index_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start_s = 1'b0;
  logic        clear = 1'b0;
  logic        en = 1'b0;
  logic [15:0] inner_max = '0;
  logic [15:0] outer_max = '0;

  logic [15:0] inner, outer;
  logic        valid, first, last, wrap, done;
  logic [1:0]  s_inner;
  logic [2:0]  s_outer;
  logic        s_valid, s_first, s_last, s_wrap, s_done;

  int num_compared = 0;
  int num_mismatched = 0;

  always #5 clk = ~clk;

  nested_index_counter #(.INNER_WIDTH(16), .OUTER_WIDTH(16)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .clear_i(clear), .en_i(en),
    .inner_max_i(inner_max), .outer_max_i(outer_max),
    .inner_o(inner), .outer_o(outer), .valid_o(valid), .first_o(first),
    .last_o(last), .inner_wrap_o(wrap), .done_o(done)
  );

  nested_index_counter #(.INNER_WIDTH(2), .OUTER_WIDTH(3)) dut_small (
    .clk_i(clk), .reset_i(reset), .start_i(start_s), .clear_i(clear), .en_i(en),
    .inner_max_i(2'b11), .outer_max_i(3'b111),
    .inner_o(s_inner), .outer_o(s_outer), .valid_o(s_valid), .first_o(s_first),
    .last_o(s_last), .inner_wrap_o(s_wrap), .done_o(s_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic startFrame(input bit sel, input int im, input int om);
    @(negedge clk);
    if (sel) start_s = 1'b1;
    else begin
      start = 1'b1;
      inner_max = 16'(im);
      outer_max = 16'(om);
    end
    @(negedge clk);
    start = 1'b0;
    start_s = 1'b0;
  endtask

  // Walks a frame from its first RUN cycle to the done cycle, checking every
  // cycle against a reference model. en_mode 1 toggles en randomly; disturb
  // pulses start with a new inner limit at the fourth beat.
  task automatic walkFrame(input bit sel, input int im, input int om,
                           input bit en_mode, input bit disturb);
    int exp_i = 0;
    int exp_o = 0;
    int beats = 0;
    int budget = 8 * (im + 1) * (om + 1) + 20;
    bit finished = 0;
    logic [31:0] o_i, o_o, o_v, o_f, o_l, o_w;
    while (!finished && budget > 0) begin
      budget--;
      o_i = sel ? 32'(s_inner) : 32'(inner);
      o_o = sel ? 32'(s_outer) : 32'(outer);
      o_v = sel ? 32'(s_valid) : 32'(valid);
      o_f = sel ? 32'(s_first) : 32'(first);
      o_l = sel ? 32'(s_last) : 32'(last);
      o_w = sel ? 32'(s_wrap) : 32'(wrap);
      checkOutput("valid", o_v, 1);
      checkOutput("inner", o_i, 32'(exp_i));
      checkOutput("outer", o_o, 32'(exp_o));
      checkOutput("first", o_f, 32'(exp_i == 0 && exp_o == 0));
      checkOutput("last", o_l, 32'(exp_i == im && exp_o == om));
      checkOutput("wrap", o_w, 32'(exp_i == im));
      en = en_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (disturb && beats == 3) begin
        start = 1'b1;
        inner_max = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (en) begin
        beats++;
        if (exp_i == im && exp_o == om) finished = 1;
        else if (exp_i == im) begin
          exp_i = 0;
          exp_o++;
        end else exp_i++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    en = 1'b0;
    if (!finished) checkOutput("frame_timeout", 0, 1);
    checkOutput("beat_count", 32'(beats), 32'((im + 1) * (om + 1)));
    checkOutput("end_valid", sel ? 32'(s_valid) : 32'(valid), 0);
    checkOutput("end_done", sel ? 32'(s_done) : 32'(done), 1);
    checkOutput("end_inner", sel ? 32'(s_inner) : 32'(inner), 0);
    checkOutput("end_outer", sel ? 32'(s_outer) : 32'(outer), 0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, 32'(valid), 0);
    checkOutput({tag, "_inner"}, 32'(inner), 0);
    checkOutput({tag, "_outer"}, 32'(outer), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic applyStimulus();
    // Reset state
    repeat (2) @(negedge clk);
    checkIdle("reset");
    checkOutput("reset_first", 32'(first), 0);
    reset = 1'b0;
    @(negedge clk);
    checkIdle("idle");

    // 3/2 frame, en held high
    startFrame(0, 3, 2);
    walkFrame(0, 3, 2, 0, 0);
    @(negedge clk);
    checkOutput("done_pulse_drop", 32'(done), 0);

    // Same frame with random en stalls
    startFrame(0, 3, 2);
    walkFrame(0, 3, 2, 1, 0);

    // Single-beat frame
    startFrame(0, 0, 0);
    walkFrame(0, 0, 0, 0, 0);

    // All-ones limits on the small instance
    startFrame(1, 0, 0);
    walkFrame(1, 3, 7, 0, 0);

    // Limit change and start pulse mid-frame are ignored
    startFrame(0, 5, 1);
    walkFrame(0, 5, 1, 0, 1);

    // clear at beat 5 of a 3/2 frame
    startFrame(0, 3, 2);
    en = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("pre_clear_outer", 32'(outer), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    en = 1'b0;
    checkIdle("clear");
    @(negedge clk);
    checkIdle("clear_after");

    // clear with start in IDLE
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    checkIdle("clear_start");
    @(negedge clk);
    checkIdle("clear_start_after");

    // Restart in the done cycle
    startFrame(0, 0, 0);
    walkFrame(0, 0, 0, 0, 0);
    start = 1'b1;
    inner_max = 16'd1;
    outer_max = 16'd0;
    @(negedge clk);
    start = 1'b0;
    walkFrame(0, 1, 0, 0, 0);

    // Async reset mid-cycle during RUN
    startFrame(0, 3, 2);
    en = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_inner", 32'(inner), 2);
    #2 reset = 1'b1;
    #1;
    checkIdle("async_reset");
    #1 reset = 1'b0;
    en = 1'b0;
    @(negedge clk);
    checkIdle("post_reset");
  endtask

  initial begin
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
